obi_mem_responder: RTL and testbench
====================================

Name: obi_mem_responder

Overview:
- Parametrised OBI-compliant memory slave that answers the core's instruction or data port.
- Replaces the fixed-timing memory model behind the core's instruction/data signal bundles.
- Adds four capabilities: configurable width and depth, programmable grant delay and response latency, multiple in-flight transactions, and error responses for out-of-range addresses.
- One instance serves one port; two instances serve the instruction and data ports.

Parameters:
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, data width; multiple of 8
- MEM_WORDS, 1024, memory depth in DATA_WIDTH words
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions; ≥1
- GNT_DELAY, 0, cycles req_i must be held before gnt_o asserts
- RVALID_LATENCY, 1, cycles from grant to rvalid_o; ≥1

Ports:
- clk  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  1  request
- gnt_o  output  1  grant
- addr_i  input  ADDR_WIDTH  byte address
- we_i  input  1  write enable
- be_i  input  DATA_WIDTH/8  byte enables
- wdata_i  input  DATA_WIDTH  write data
- rvalid_o  output  1  response valid
- rdata_o  output  DATA_WIDTH  read data; 0 on write or error
- err_o  output  1  response error, qualified by rvalid_o
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  in-flight transaction count

Behaviour:
- Clock and reset: single clock clk; rst_ni is asynchronous, active-low.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, outstanding_o=0. The wait counter and response FIFO clear. The memory array is not reset.
- Address phase, wait counter:
  - wait_cnt increments each cycle in which req_i=1 and no grant occurs.
  - It clears on grant, or whenever req_i=0.
- Address phase, grant condition: gnt_o = req_i && (wait_cnt==GNT_DELAY) && (count<MAX_OUTSTANDING). gnt_o is combinational.
  - GNT_DELAY=0 gives a same-cycle grant.
  - Full FIFO: no grant, and wait_cnt saturates at GNT_DELAY.
  - A pop in the same cycle does not free a slot for a grant.
- Handshake: a transfer occurs on req_i&&gnt_o. Masters hold addr/we/be/wdata stable until granted; the block does not check this.
- Address decode: word index = addr_i[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]. The address is in range when index < MEM_WORDS. Low address bits are ignored.
- At grant, write (we_i=1, in range): bytes with be_i[k]=1 are updated in the same clock edge.
- At grant, read (in range): the current word is captured into the FIFO entry. A write granted earlier is visible to a later read.
- At grant, out of range: no memory access; the entry is marked err=1 with rdata 0.
- Response FIFO, entries: each granted transaction pushes {rdata, err, cnt=RVALID_LATENCY-1} into an in-order FIFO of depth MAX_OUTSTANDING.
- Response FIFO, countdown: every cycle, each valid entry with cnt>0 decrements its cnt.
- Response FIFO, pop: when the head has cnt==0, the next cycle presents rvalid_o=1 with its rdata and err, then pops. Responses are registered.
  - One response per cycle.
  - A younger entry whose count has expired waits for the head, so responses stay in order.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Latency: with GNT_DELAY=0, RVALID_LATENCY=L and an empty FIFO, a transaction granted in cycle N gives rvalid_o=1 in cycle N+L.
- Back-to-back: with RVALID_LATENCY=1, throughput is one transaction per cycle while the FIFO is not full.
- Reset mid-operation: pending responses are discarded and never emitted. Writes already granted remain in memory.
- rdata_o and err_o are 0 whenever rvalid_o=0.

Decomposition:
- Shared package riscv_obi_pkg holds:
  - the response-entry struct type (rdata, err, latency count);
  - the parameter-derived width function for the counters.
- Natural sub-module obi_resp_fifo: in-order, parametrised depth, per-entry countdown, head-ready output, push/pop.
- The top level holds the grant logic, address decode and memory array.

Test Plan:
- Defaults (GNT_DELAY=0, L=1):
  - Write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 → read rvalid 1 cycle after its grant, rdata=0xDEADBEEF, err=0.
  - Then write 0x000000AA to 0x10 with be=4'b0001, and read 0x10 → rdata=0xDEADBEAA.
- GNT_DELAY=2, RVALID_LATENCY=3, req_i held → gnt_o in the 3rd req cycle; rvalid 3 cycles after the grant.
  - Dropping req_i after 1 cycle and re-raising it → the count restarts at 0.
- MAX_OUTSTANDING=2, L=5, four back-to-back reads of 0x0,0x4,0x8,0xC:
  - gnt_o low after 2 grants; outstanding_o=2.
  - Third grant only once a response has popped.
  - Responses emerge in address order.
- Read at 0x1000 (MEM_WORDS=1024) → rvalid with err=1, rdata=0.
  - Write to 0x1000 → err=1, and no in-range word is modified.
- rst_ni pulsed low with 3 responses pending → rvalid_o=0 and outstanding_o=0 immediately; no stale response afterwards.
  - A subsequent read of a pre-reset written address returns the written value.
- Randomised req timing against a reference queue over 10k transactions → in-order, correct data, rvalid never exceeds one per cycle.

Source files
------------

// File: rtl/riscv_obi_pkg.sv
// Shared types and helpers for the OBI memory responder.
// resp_entry_t is sized for the widest supported port (64-bit data, latency up to 256).
package riscv_obi_pkg;

    localparam int unsigned RESP_DATA_W = 64;
    localparam int unsigned RESP_CNT_W  = 8;

    typedef struct packed {
        logic [RESP_DATA_W-1:0] rdata;
        logic                   err;
        logic [RESP_CNT_W-1:0]  cnt;
    } resp_entry_t;

    // Bits needed to hold any value in 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response queue with a per-entry latency countdown.
// Younger entries keep counting while the head waits, so they can leave back-to-back.
module obi_resp_fifo
    import riscv_obi_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_ni,
    input  logic                          push,
    input  resp_entry_t                   push_entry,
    input  logic                          pop,
    output logic                          head_ready,
    output resp_entry_t                   head_entry,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    resp_entry_t            entries [DEPTH];
    logic [DEPTH-1:0]       valid;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            entries <= '{default: '0};
            valid   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && (entries[i].cnt != '0)) begin
                    entries[i].cnt <= entries[i].cnt - RESP_CNT_W'(1);
                end
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= next_ptr(rd_ptr);
            end
            // The push slot is always free, so it safely overrides the countdown above.
            if (push) begin
                entries[wr_ptr] <= push_entry;
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_entry = entries[rd_ptr];
    assign head_ready = valid[rd_ptr] && (entries[rd_ptr].cnt == '0);

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory slave: programmable grant delay, response latency and outstanding depth,
// with error responses for addresses beyond the memory array.
module obi_mem_responder
    import riscv_obi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MEM_WORDS       = 1024,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned GNT_DELAY       = 0,
    parameter int unsigned RVALID_LATENCY  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_ni,
    input  logic                                   req_i,
    output logic                                   gnt_o,
    input  logic [ADDR_WIDTH-1:0]                  addr_i,
    input  logic                                   we_i,
    input  logic [DATA_WIDTH/8-1:0]                be_i,
    input  logic [DATA_WIDTH-1:0]                  wdata_i,
    output logic                                   rvalid_o,
    output logic [DATA_WIDTH-1:0]                  rdata_o,
    output logic                                   err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned OFFS_W    = $clog2(BYTES);
    localparam int unsigned IDX_W     = ADDR_WIDTH - OFFS_W;
    localparam int unsigned MEM_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned WAIT_W    = cnt_width(GNT_DELAY);
    localparam int unsigned OUT_W     = cnt_width(MAX_OUTSTANDING);

    localparam logic [IDX_W:0]      MEM_LIMIT  = (IDX_W + 1)'(MEM_WORDS);
    localparam logic [WAIT_W-1:0]   WAIT_LIMIT = WAIT_W'(GNT_DELAY);
    localparam logic [OUT_W-1:0]    OUT_LIMIT  = OUT_W'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0]  mem [MEM_WORDS];
    logic [WAIT_W-1:0]      wait_cnt;
    logic [IDX_W-1:0]       word_idx;
    logic [MEM_IDX_W-1:0]   mem_idx;
    logic                   in_range;
    logic [OUT_W-1:0]       fifo_count;
    logic                   head_ready;
    resp_entry_t            head_entry;
    resp_entry_t            push_entry;

    assign word_idx = addr_i[ADDR_WIDTH-1:OFFS_W];
    assign mem_idx  = word_idx[MEM_IDX_W-1:0];
    assign in_range = ({1'b0, word_idx} < MEM_LIMIT);

    // A pop in this cycle deliberately does not free a slot: fifo_count is the registered value.
    assign gnt_o = rst_ni && req_i && (wait_cnt == WAIT_LIMIT) && (fifo_count < OUT_LIMIT);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (!req_i || gnt_o) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // The array is intentionally not reset so granted writes survive a reset pulse.
    always_ff @(posedge clk) begin
        if (gnt_o && we_i && in_range) begin
            for (int k = 0; k < BYTES; k++) begin
                if (be_i[k]) begin
                    mem[mem_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        push_entry     = '0;
        push_entry.cnt = RESP_CNT_W'(RVALID_LATENCY - 1);
        if (!in_range) begin
            push_entry.err = 1'b1;
        end else if (!we_i) begin
            push_entry.rdata[DATA_WIDTH-1:0] = mem[mem_idx];
        end
    end

    obi_resp_fifo #(
        .DEPTH      (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .push       (gnt_o),
        .push_entry (push_entry),
        .pop        (head_ready),
        .head_ready (head_ready),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

    assign outstanding_o = fifo_count;
    assign rvalid_o      = head_ready;
    assign rdata_o       = head_ready ? head_entry.rdata[DATA_WIDTH-1:0] : '0;
    assign err_o         = head_ready && head_entry.err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Randomised scoreboard bench for obi_mem_responder with a transaction-level reference model.
module tb_obi_mem_responder;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MEM_WORDS  = 1024;
    localparam int MAX_OUT    = 3;
    localparam int GNT_DELAY  = 1;
    localparam int LAT        = 6;
    localparam int TEST_WORDS = 64;
    localparam int N_RANDOM   = 10000;
    localparam int OUT_W      = $clog2(MAX_OUT + 1);

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_i = 1'b0;
    logic              gnt_o;
    logic [AW-1:0]     addr_i = '0;
    logic              we_i = 1'b0;
    logic [DW/8-1:0]   be_i = '0;
    logic [DW-1:0]     wdata_i = '0;
    logic              rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic [OUT_W-1:0]  outstanding_o;

    obi_mem_responder #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MEM_WORDS       (MEM_WORDS),
        .MAX_OUTSTANDING (MAX_OUT),
        .GNT_DELAY       (GNT_DELAY),
        .RVALID_LATENCY  (LAT)
    ) dut (
        .clk             (clk),
        .rst_ni          (rst_ni),
        .req_i           (req_i),
        .gnt_o           (gnt_o),
        .addr_i          (addr_i),
        .we_i            (we_i),
        .be_i            (be_i),
        .wdata_i         (wdata_i),
        .rvalid_o        (rvalid_o),
        .rdata_o         (rdata_o),
        .err_o           (err_o),
        .outstanding_o   (outstanding_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;

    exp_t          sb[$];
    int            due_q[$];
    int            last_due = -1;
    int            waited = 0;
    logic [DW-1:0] mem_m [MEM_WORDS];
    int            check_cnt = 0;
    int            pass_cnt = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // Reference behaviour of one granted transfer: memory effect and the response it owes.
    function automatic exp_t modelTransfer(input logic [AW-1:0] addr, input logic we,
                                           input logic [DW/8-1:0] be, input logic [DW-1:0] wdata,
                                           input int due);
        exp_t e;
        int   idx;
        e.due   = due;
        e.rdata = '0;
        e.err   = 1'b0;
        idx     = int'(addr >> 2);
        if (idx >= MEM_WORDS) begin
            e.err = 1'b1;
        end else if (we) begin
            for (int k = 0; k < DW/8; k++) begin
                if (be[k]) mem_m[idx][8*k +: 8] = wdata[8*k +: 8];
            end
        end else begin
            e.rdata = mem_m[idx];
        end
        return e;
    endfunction

    // One clock of the model: decides the grant, checks grant and occupancy, books responses.
    task automatic stepCycle(output bit granted);
        int   out_now;
        bit   exp_gnt;
        int   due;
        exp_t e;
        @(negedge clk);
        while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
        out_now = due_q.size();
        exp_gnt = req_i && (waited == GNT_DELAY) && (out_now < MAX_OUT);
        checkOutput("gnt", 64'(gnt_o), 64'(exp_gnt));
        checkOutput("outstanding", 64'(outstanding_o), 64'(out_now));
        if (exp_gnt) begin
            due      = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
            last_due = due;
            due_q.push_back(due);
            e = modelTransfer(addr_i, we_i, be_i, wdata_i, due);
            sb.push_back(e);
            waited = 0;
        end else if (req_i) begin
            if (waited < GNT_DELAY) waited++;
        end else begin
            waited = 0;
        end
        granted = exp_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr, input logic we, input logic [DW/8-1:0] be,
                                 input logic [DW-1:0] wdata, input bit drop);
        bit g;
        int budget;
        addr_i  = addr;
        we_i    = we;
        be_i    = be;
        wdata_i = wdata;
        req_i   = 1'b1;
        g       = 1'b0;
        if (drop) begin
            stepCycle(g);
            if (!g) begin
                req_i = 1'b0;
                stepCycle(g);
                req_i = 1'b1;
            end
        end
        budget = 0;
        while (!g && budget < 64) begin
            stepCycle(g);
            budget++;
        end
        if (!g) begin
            check_cnt++;
            $display("[TB] FAIL grant_timeout: no grant after %0d cycles, required within 64", budget);
        end
    endtask

    task automatic idleCycles(input int n);
        bit g;
        req_i = 1'b0;
        repeat (n) stepCycle(g);
    endtask

    // Scoreboard monitor: every cycle the head response is either due now or nothing is shown.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   exp_rv;
        exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
        checkOutput("rvalid", 64'(rvalid_o), 64'(exp_rv));
        if (exp_rv) begin
            e = sb.pop_front();
            if (rvalid_o) begin
                checkOutput("rdata", 64'(rdata_o), 64'(e.rdata));
                checkOutput("err", 64'(err_o), 64'(e.err));
            end
        end else begin
            checkOutput("idle_rdata", 64'(rdata_o), 64'(0));
            checkOutput("idle_err", 64'(err_o), 64'(0));
        end
    end

    initial begin
        logic [AW-1:0] a;
        int            drain;

        req_i = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_gnt", 64'(gnt_o), 64'(0));
        checkOutput("reset_rvalid", 64'(rvalid_o), 64'(0));
        checkOutput("reset_outstanding", 64'(outstanding_o), 64'(0));
        checkOutput("reset_rdata", 64'(rdata_o), 64'(0));
        checkOutput("reset_err", 64'(err_o), 64'(0));
        req_i  = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int w = 0; w < TEST_WORDS; w++) begin
            applyStimulus(32'(w * 4), 1'b1, 4'hF, (w == 4) ? 32'hDEADBEEF : 32'($urandom()), 1'b0);
        end
        applyStimulus(32'h10, 1'b0, 4'hF, '0, 1'b0);
        applyStimulus(32'h10, 1'b1, 4'b0001, 32'h0000_00AA, 1'b0);
        applyStimulus(32'h10, 1'b0, 4'hF, '0, 1'b0);
        idleCycles(LAT + 2);

        applyStimulus(32'h1000, 1'b0, 4'hF, '0, 1'b0);
        applyStimulus(32'h1000, 1'b1, 4'hF, 32'h1234_5678, 1'b0);
        applyStimulus(32'h0, 1'b0, 4'hF, '0, 1'b0);
        applyStimulus(32'h14, 1'b0, 4'hF, '0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(32'(i * 4), 1'b0, 4'hF, '0, 1'b0);
        idleCycles(LAT + 2);

        for (int i = 0; i < 3; i++) applyStimulus(32'(32 + i * 4), 1'b0, 4'hF, '0, 1'b0);
        req_i  = 1'b0;
        rst_ni = 1'b0;
        #1;
        checkOutput("midreset_rvalid", 64'(rvalid_o), 64'(0));
        checkOutput("midreset_outstanding", 64'(outstanding_o), 64'(0));
        checkOutput("midreset_gnt", 64'(gnt_o), 64'(0));
        sb.delete();
        due_q.delete();
        waited   = 0;
        last_due = -1;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        idleCycles(LAT + 4);
        applyStimulus(32'h10, 1'b0, 4'hF, '0, 1'b0);
        idleCycles(2);

        for (int n = 0; n < N_RANDOM; n++) begin
            if ($urandom_range(0, 15) == 0) a = 32'($urandom()) | 32'h0000_1000;
            else a = 32'($urandom_range(0, TEST_WORDS - 1) * 4 + $urandom_range(0, 3));
            applyStimulus(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          32'($urandom()), $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end

        drain = 0;
        while (sb.size() > 0 && drain < 200) begin
            idleCycles(1);
            drain++;
        end
        if (sb.size() > 0) begin
            check_cnt++;
            $display("[TB] FAIL drain: %0d responses still pending, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
